// File: rtl/alu_dp_controller.sv
// -----------------------------------------------------------------------------
// alu_dp_controller
//
// Multi-cycle sequencer for ARM-style data-processing instructions executed on
// a shared combinational ALU. It owns the architectural NZCV flags and checks
// each instruction's condition field against them. It drives the ALU opcode
// and carry-in, captures the ALU result and flags, and then issues a one-cycle
// register-file write strobe.
//
// Sequence: IDLE -> COND -> EXEC -> WB -> IDLE   (condition passed)
//           IDLE -> COND -> SKIP -> IDLE         (condition failed)
//
// Ports
//   clk            in   system clock, rising edge
//   reset_n        in   asynchronous active-low reset
//   start          in   execute request, sampled only in IDLE
//   instr[31:0]    in   [31:28] cond, [24:21] opcode, [20] S, [15:12] Rd
//   shifter_carry  in   barrel-shifter carry-out, becomes C for logical ops
//   flags_load     in   external NZCV write, honoured only in IDLE
//   flags_in[3:0]  in   NZCV value for flags_load
//   alu_out[DW-1:0] in  ALU result
//   alu_c/z/n/v    in   ALU flag outputs
//   alu_op[OPW-1:0] out ALU opcode (IDLE_OP outside EXEC)
//   alu_carry_in   out  current C flag
//   rf_we          out  register-file write strobe, one cycle
//   rf_waddr[3:0]  out  destination register Rd
//   rf_wdata[DW-1:0] out registered ALU result
//   nzcv[3:0]      out  architectural flags {N,Z,C,V}
//   busy           out  high in every state except IDLE
//   done           out  one-cycle completion pulse
//   cond_pass      out  registered condition result of the current/last instr
// -----------------------------------------------------------------------------
module alu_dp_controller #(
    parameter int             DW      = 32,
    parameter int             OPW     = 5,
    parameter logic [OPW-1:0] IDLE_OP = 5'b11111
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic           start,
    input  logic [31:0]    instr,
    input  logic           shifter_carry,
    input  logic           flags_load,
    input  logic [3:0]     flags_in,
    input  logic [DW-1:0]  alu_out,
    input  logic           alu_c,
    input  logic           alu_z,
    input  logic           alu_n,
    input  logic           alu_v,
    output logic [OPW-1:0] alu_op,
    output logic           alu_carry_in,
    output logic           rf_we,
    output logic [3:0]     rf_waddr,
    output logic [DW-1:0]  rf_wdata,
    output logic [3:0]     nzcv,
    output logic           busy,
    output logic           done,
    output logic           cond_pass
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_COND,
        S_EXEC,
        S_WB,
        S_SKIP
    } state_t;

    // Bit positions of the individual flags inside nzcv.
    localparam int FN = 3;
    localparam int FZ = 2;
    localparam int FC = 1;
    localparam int FV = 0;

    state_t state;
    state_t next_state;

    logic [31:0] instr_q;        // instruction latched on acceptance
    logic [3:0]  flag_cand;      // flag value computed at the end of EXEC
    logic        flag_wr;        // flag_cand is committed in WB

    logic [3:0]  cond_code;
    logic [3:0]  opcode;
    logic        cond_ok;
    logic        is_test;        // TST/TEQ/CMP/CMN: flags only, no Rd write
    logic        is_arith;       // flag C/V come from the adder

    assign cond_code = instr_q[31:28];
    assign opcode    = instr_q[24:21];
    assign is_test   = (opcode[3:2] == 2'b10);

    // SUB, RSB, ADD, ADC, SBC, RSC (0010-0111) and CMP, CMN (1010, 1011).
    assign is_arith  = ((opcode >= 4'b0010) && (opcode <= 4'b0111)) ||
                       (opcode == 4'b1010) || (opcode == 4'b1011);

    // ARM condition-code evaluation against the architectural flags.
    function automatic logic cond_true(input logic [3:0] code, input logic [3:0] f);
        logic n;
        logic z;
        logic c;
        logic v;
        logic r;
        n = f[FN];
        z = f[FZ];
        c = f[FC];
        v = f[FV];
        case (code)
            4'b0000: r = z;                   // EQ
            4'b0001: r = !z;                  // NE
            4'b0010: r = c;                   // CS
            4'b0011: r = !c;                  // CC
            4'b0100: r = n;                   // MI
            4'b0101: r = !n;                  // PL
            4'b0110: r = v;                   // VS
            4'b0111: r = !v;                  // VC
            4'b1000: r = c && !z;             // HI
            4'b1001: r = !c || z;             // LS
            4'b1010: r = (n == v);            // GE
            4'b1011: r = (n != v);            // LT
            4'b1100: r = !z && (n == v);      // GT
            4'b1101: r = z || (n != v);       // LE
            4'b1110: r = 1'b1;                // AL
            default: r = 1'b0;                // 1111: never
        endcase
        return r;
    endfunction

    assign cond_ok = cond_true(cond_code, nzcv);

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    // NOTE: every clocked process uses non-blocking (<=) assignments so that
    // all registers update together from pre-edge values; a blocking update
    // would let later statements see the new value within the same edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state and decoded ALU controls
    // -------------------------------------------------------------------------
    // NOTE: every output of this combinational block is given a default before
    // the case statement; a path that leaves one unassigned would infer a latch.
    always_comb begin
        next_state   = state;
        alu_op       = IDLE_OP;
        alu_carry_in = nzcv[FC];
        case (state)
            S_IDLE: begin
                if (start) begin
                    next_state = S_COND;
                end
            end
            S_COND: begin
                next_state = cond_ok ? S_EXEC : S_SKIP;
            end
            S_EXEC: begin
                alu_op     = {{(OPW-4){1'b0}}, opcode};
                next_state = S_WB;
            end
            S_WB: begin
                next_state = S_IDLE;
            end
            S_SKIP: begin
                next_state = S_IDLE;
            end
            default: begin
                next_state = S_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Datapath and registered outputs
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            instr_q   <= '0;
            flag_cand <= '0;
            flag_wr   <= 1'b0;
            nzcv      <= 4'b0000;
            cond_pass <= 1'b0;
            rf_wdata  <= '0;
            rf_waddr  <= '0;
            rf_we     <= 1'b0;
            done      <= 1'b0;
            busy      <= 1'b0;
        end else begin
            // Status outputs are registered off the next state so they line up
            // with the state they describe.
            busy  <= (next_state != S_IDLE);
            done  <= (next_state == S_WB) || (next_state == S_SKIP);
            rf_we <= (state == S_EXEC) && !is_test;

            case (state)
                S_IDLE: begin
                    // start has priority; a simultaneous flags_load is dropped.
                    if (start) begin
                        instr_q <= instr;
                    end else if (flags_load) begin
                        nzcv <= flags_in;
                    end
                end
                S_COND: begin
                    cond_pass <= cond_ok;
                end
                S_EXEC: begin
                    rf_wdata <= alu_out;
                    rf_waddr <= instr_q[15:12];
                    flag_wr  <= instr_q[20] || is_test;
                    // Logical ops take C from the shifter and keep V.
                    if (is_arith) begin
                        flag_cand <= {alu_n, alu_z, alu_c, alu_v};
                    end else begin
                        flag_cand <= {alu_n, alu_z, shifter_carry, nzcv[FV]};
                    end
                end
                S_WB: begin
                    if (flag_wr) begin
                        nzcv <= flag_cand;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_dp_controller.sv
// -----------------------------------------------------------------------------
// tb_alu_dp_controller
//
// Self-checking bench for alu_dp_controller. The bench plays both the decode
// stage and the ALU: for each instruction it presents fixed ALU result/flag
// values and predicts the timing, write-back and flag outcome from an
// instruction-level model of the architecture.
// -----------------------------------------------------------------------------
module tb_alu_dp_controller;

    localparam int             DW      = 32;
    localparam int             OPW     = 5;
    localparam logic [OPW-1:0] IDLE_OP = 5'b11111;

    logic           clk;
    logic           reset_n;
    logic           start;
    logic [31:0]    instr;
    logic           shifter_carry;
    logic           flags_load;
    logic [3:0]     flags_in;
    logic [DW-1:0]  alu_out;
    logic           alu_c;
    logic           alu_z;
    logic           alu_n;
    logic           alu_v;
    logic [OPW-1:0] alu_op;
    logic           alu_carry_in;
    logic           rf_we;
    logic [3:0]     rf_waddr;
    logic [DW-1:0]  rf_wdata;
    logic [3:0]     nzcv;
    logic           busy;
    logic           done;
    logic           cond_pass;

    int n_checks;
    int n_fail;

    logic [3:0] m_nzcv;   // architectural flags according to the model

    alu_dp_controller #(.DW(DW), .OPW(OPW), .IDLE_OP(IDLE_OP)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .start         (start),
        .instr         (instr),
        .shifter_carry (shifter_carry),
        .flags_load    (flags_load),
        .flags_in      (flags_in),
        .alu_out       (alu_out),
        .alu_c         (alu_c),
        .alu_z         (alu_z),
        .alu_n         (alu_n),
        .alu_v         (alu_v),
        .alu_op        (alu_op),
        .alu_carry_in  (alu_carry_in),
        .rf_we         (rf_we),
        .rf_waddr      (rf_waddr),
        .rf_wdata      (rf_wdata),
        .nzcv          (nzcv),
        .busy          (busy),
        .done          (done),
        .cond_pass     (cond_pass)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ARM condition table written from the architecture definition.
    function automatic bit cond_model(input logic [3:0] code, input logic [3:0] f);
        bit n;
        bit z;
        bit c;
        bit v;
        n = f[3];
        z = f[2];
        c = f[1];
        v = f[0];
        case (code)
            4'd0:    return z;
            4'd1:    return !z;
            4'd2:    return c;
            4'd3:    return !c;
            4'd4:    return n;
            4'd5:    return !n;
            4'd6:    return v;
            4'd7:    return !v;
            4'd8:    return c && !z;
            4'd9:    return !c || z;
            4'd10:   return n == v;
            4'd11:   return n != v;
            4'd12:   return !z && (n == v);
            4'd13:   return z || (n != v);
            4'd14:   return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // MSR-style flag write while idle. Called on a falling edge.
    task automatic load_flags(input logic [3:0] val);
        flags_load = 1'b1;
        flags_in   = val;
        @(negedge clk);
        flags_load = 1'b0;
        m_nzcv     = val;
        check("msr_nzcv", {28'd0, nzcv}, {28'd0, m_nzcv});
    endtask

    // Issue one instruction and check it end to end. Called on a falling edge
    // with the DUT idle; returns on a falling edge with the DUT idle.
    // af = ALU flags {N,Z,C,V}; with_fl raises flags_load alongside start.
    task automatic exec_instr(input logic [31:0] ins, input logic [31:0] aout,
                              input logic [3:0] af, input logic sc,
                              input bit with_fl, input logic [3:0] fl_val);
        bit         exp_pass;
        int         exp_lat;
        bit         exp_we;
        logic [3:0] op;
        logic [3:0] exp_nzcv;
        logic [3:0] nzcv_before;
        int         done_cyc;
        int         done_cnt;
        int         we_cnt;
        logic [3:0]  seen_waddr;
        logic [31:0] seen_wdata;

        op          = ins[24:21];
        nzcv_before = m_nzcv;
        exp_pass    = cond_model(ins[31:28], m_nzcv);
        exp_lat     = exp_pass ? 3 : 2;
        exp_we      = exp_pass && !(op >= 4'd8 && op <= 4'd11);
        exp_nzcv    = m_nzcv;
        if (exp_pass && (ins[20] || (op >= 4'd8 && op <= 4'd11))) begin
            if ((op >= 4'd2 && op <= 4'd7) || op == 4'd10 || op == 4'd11) begin
                exp_nzcv = af;
            end else begin
                exp_nzcv = {af[3], af[2], sc, m_nzcv[0]};
            end
        end

        instr         = ins;
        alu_out       = aout;
        {alu_n, alu_z, alu_c, alu_v} = af;
        shifter_carry = sc;
        start         = 1'b1;
        flags_load    = with_fl;
        flags_in      = fl_val;
        @(posedge clk);           // start accepted on this edge
        done_cyc   = 0;
        done_cnt   = 0;
        we_cnt     = 0;
        seen_waddr = '0;
        seen_wdata = '0;
        for (int cyc = 1; cyc <= 6; cyc++) begin
            @(negedge clk);
            flags_load = 1'b0;
            if (cyc == 1) begin
                check("busy_cond", {31'd0, busy}, 32'd1);
            end
            if (cyc == 2 && exp_pass) begin
                check("exec_alu_op", {27'd0, alu_op}, {28'd0, op});
                check("exec_carry_in", {31'd0, alu_carry_in}, {31'd0, nzcv_before[1]});
            end
            if (cyc == 2) begin
                check("cond_pass", {31'd0, cond_pass}, {31'd0, exp_pass});
            end
            if (done) begin
                done_cnt++;
                if (done_cyc == 0) done_cyc = cyc;
                start = 1'b0;     // decode drops start once it sees done
            end
            if (rf_we) begin
                we_cnt++;
                seen_waddr = rf_waddr;
                seen_wdata = rf_wdata;
            end
        end
        start = 1'b0;
        check("done_latency", done_cyc, exp_lat);
        check("done_count", done_cnt, 1);
        check("rf_we_count", we_cnt, {31'd0, exp_we});
        if (exp_we) begin
            check("rf_waddr", {28'd0, seen_waddr}, {28'd0, ins[15:12]});
            check("rf_wdata", seen_wdata, aout);
        end
        m_nzcv = exp_nzcv;
        check("nzcv", {28'd0, nzcv}, {28'd0, m_nzcv});
        check("idle_busy", {31'd0, busy}, 32'd0);
        check("idle_alu_op", {27'd0, alu_op}, {27'd0, IDLE_OP});
    endtask

    initial begin
        n_checks      = 0;
        n_fail        = 0;
        m_nzcv        = 4'b0000;
        reset_n       = 1'b0;
        start         = 1'b0;
        instr         = '0;
        shifter_carry = 1'b0;
        flags_load    = 1'b0;
        flags_in      = '0;
        alu_out       = '0;
        {alu_n, alu_z, alu_c, alu_v} = 4'b0000;

        repeat (3) @(negedge clk);
        check("rst_nzcv", {28'd0, nzcv}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_rf_we", {31'd0, rf_we}, 32'd0);
        check("rst_wdata", rf_wdata, 32'd0);
        check("rst_waddr", {28'd0, rf_waddr}, 32'd0);
        check("rst_cond_pass", {31'd0, cond_pass}, 32'd0);
        check("rst_alu_op", {27'd0, alu_op}, {27'd0, IDLE_OP});
        reset_n = 1'b1;
        @(negedge clk);

        // ADDS, cond AL, zero result with carry -> nzcv 0110.
        exec_instr(32'hE090_0000, 32'h0000_0000, 4'b0110, 1'b0, 1'b0, 4'h0);
        // MSR Z, then MOVNE -> skipped, flags kept.
        load_flags(4'b0100);
        exec_instr(32'h11A0_0000, 32'h1234_5678, 4'b1111, 1'b1, 1'b0, 4'h0);
        // CMP with N and V from the ALU -> nzcv 1001, no write.
        exec_instr(32'hE150_0000, 32'hFFFF_FFFF, 4'b1001, 1'b0, 1'b0, 4'h0);
        // ANDS keeps V, C from shifter -> nzcv 1011.
        load_flags(4'b0001);
        exec_instr(32'hE010_3000, 32'h8000_0000, 4'b1000, 1'b1, 1'b0, 4'h0);
        // ADC with C set -> carry_in 1, flags untouched (S=0).
        load_flags(4'b0010);
        exec_instr(32'hE0A0_5000, 32'hCAFE_F00D, 4'b1101, 1'b0, 1'b0, 4'h0);
        // start and flags_load together: start wins, flags_load dropped.
        exec_instr(32'hE1A0_7000, 32'h0000_0077, 4'b0000, 1'b0, 1'b1, 4'b1111);

        // Reset during EXEC: everything cleared at once, no write-back.
        load_flags(4'b1010);
        instr   = 32'hE090_2000;
        alu_out = 32'hDEAD_BEEF;
        start   = 1'b1;
        @(posedge clk);
        @(negedge clk);
        @(negedge clk);
        check("pre_rst_exec_op", {27'd0, alu_op}, 32'd4);
        #1 reset_n = 1'b0;
        #1;
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_rf_we", {31'd0, rf_we}, 32'd0);
        check("midrst_nzcv", {28'd0, nzcv}, 32'd0);
        check("midrst_done", {31'd0, done}, 32'd0);
        start = 1'b0;
        m_nzcv = 4'b0000;
        @(negedge clk);
        reset_n = 1'b1;
        begin
            int we_seen;
            we_seen = 0;
            repeat (4) begin
                @(negedge clk);
                if (rf_we) we_seen++;
            end
            check("post_rst_no_we", we_seen, 0);
        end
        exec_instr(32'hE090_4000, 32'h0000_0042, 4'b0000, 1'b0, 1'b0, 4'h0);

        // Randomised instructions against the model.
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 2) == 0) begin
                load_flags(4'($urandom_range(0, 15)));
            end
            exec_instr($urandom, $urandom, 4'($urandom_range(0, 15)),
                       1'($urandom_range(0, 1)), ($urandom_range(0, 4) == 0),
                       4'($urandom_range(0, 15)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_dp_controller.md
Name: alu_dp_controller

Overview:
- Multi-cycle sequencer for data-processing instructions on the shared combinational 32-bit ALU.
- Holds the architectural NZCV flags and evaluates the instruction condition field against them.
- Drives the ALU opcode and carry-in, latches the ALU result and flags, then issues a one-cycle register-file write strobe.
- Sits between the decode stage (start/instr handshake) and the ALU/register file.

Parameters:
- DW, 32, datapath width of result and ALU operands.
- OPW, 5, ALU opcode width.
- IDLE_OP, 5'b11111, opcode driven when idle; selects the ALU default, output 0.

Ports:
- clk  in  1  system clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  request: execute instr; sampled only in IDLE
- instr  in  32  ARM data-processing word: [31:28] cond, [24:21] opcode, [20] S, [15:12] Rd
- shifter_carry  in  1  barrel-shifter carry-out, used as C for logical ops
- flags_load  in  1  external NZCV write (MSR); honoured only in IDLE
- flags_in  in  4  NZCV value for flags_load
- alu_out  in  DW  ALU result
- alu_c, alu_z, alu_n, alu_v  in  1 each  ALU flag outputs
- alu_op  out  OPW  ALU opcode
- alu_carry_in  out  1  current C flag
- rf_we  out  1  register-file write strobe, one cycle
- rf_waddr  out  4  destination Rd
- rf_wdata  out  DW  registered result
- nzcv  out  4  architectural flags {N,Z,C,V}
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle completion pulse
- cond_pass  out  1  registered condition result of the current/last instruction

Behaviour:
- Reset (async, reset_n=0):
  - state=IDLE, nzcv=4'b0000.
  - rf_we=0, done=0, busy=0, cond_pass=0, rf_wdata=0, rf_waddr=0.
  - alu_op=IDLE_OP.
- States: IDLE, COND, EXEC, WB, SKIP.
- IDLE:
  - alu_op=IDLE_OP.
  - start=1: latch instr, go to COND.
  - Else, if flags_load=1: nzcv<=flags_in.
  - start and flags_load together: start wins, flags_load dropped.
- COND: evaluate instr[31:28] against nzcv, register cond_pass.
  - Codes: EQ Z; NE !Z; CS C; CC !C; MI N; PL !N; VS V; VC !V; HI C&!Z; LS !C|Z; GE N==V; LT N!=V; GT !Z&(N==V); LE Z|(N!=V); AL 1; 1111 never.
  - Pass: go to EXEC. Fail: go to SKIP.
- EXEC:
  - alu_op={1'b0, instr[24:21]}, alu_carry_in=nzcv[C].
  - End of cycle: rf_wdata<=alu_out; capture the flag candidate; go to WB.
- WB:
  - done=1.
  - rf_we=1 unless opcode is TST/TEQ/CMP/CMN (1000–1011); rf_waddr=Rd.
  - Flag update when S=1, or always for 1000–1011:
    - Arithmetic (SUB, RSB, ADD, ADC, SBC, RSC, CMP, CMN): NZCV <= {alu_n, alu_z, alu_c, alu_v}.
    - Logical (AND, EOR, TST, TEQ, ORR, MOV, BIC, MVN): N <= alu_n, Z <= alu_z, C <= shifter_carry (as sampled in EXEC), V unchanged.
  - Next state: IDLE.
- SKIP: done=1, rf_we=0, nzcv unchanged; go to IDLE.
- Latency: start sampled at edge 0 → done high in cycle 3 (pass) or cycle 2 (fail). Throughput: one instruction per 4 / 3 cycles.
- start while busy is ignored (no queuing). Decode holds start until it observes done.
- Reset mid-operation: immediate return to IDLE; no rf_we, no flag update. Any in-flight rf_we pulse is cut.
- Outputs are registered, except alu_op and alu_carry_in, which are decoded from state.

Test Plan:
- Reset, then ADDS (instr=0xE0900000, cond AL), alu_out=0x00000000, alu_c=1, alu_z=1 → done at cycle 3, rf_we=1, rf_wdata=0, nzcv=4'b0110.
- flags_load=1, flags_in=4'b0100 in IDLE; then MOVNE (cond=0001) → cond_pass=0, SKIP, done at cycle 2, rf_we never asserted, nzcv=4'b0100.
- CMP (opcode 1010, S=1), alu_n=1, alu_v=1, alu_out=0xFFFFFFFF → alu_op=5'b01010 in EXEC, rf_we=0, nzcv=4'b1001.
- ANDS with nzcv=4'b0001, alu_out=0x80000000, shifter_carry=1 → nzcv=4'b1011 (V retained).
- ADC with nzcv C=1 → alu_carry_in=1 during EXEC, alu_op=5'b00101. start pulsed again in COND → ignored; exactly one done.
- reset_n low during EXEC → rf_we stays 0, busy=0 immediately, nzcv=0; next start executes normally.
